// File: rtl/service_ledger.sv
// Per-station service counters, saturating revenue total and a ticket queue
// feeding the cashier over a valid/ready handshake.
module service_ledger #(
  parameter int CNT_W      = 8,
  parameter int ACC_W      = 12,
  parameter int PRICE_WASH = 5,
  parameter int PRICE_SHOP = 9,
  parameter int FIFO_DEPTH = 4,
  localparam int PTR_W     = $clog2(FIFO_DEPTH),
  localparam int LVL_W     = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ct_wash,
  input  logic             ct_shop,
  input  logic             clr_total,
  input  logic             out_ready,
  output logic             out_valid,
  output logic             out_svc,
  output logic [CNT_W-1:0] out_id,
  output logic [CNT_W-1:0] wash_cnt,
  output logic [CNT_W-1:0] shop_cnt,
  output logic [ACC_W-1:0] total,
  output logic [LVL_W-1:0] level,
  output logic             drop
);

  // Handshake: a head record transfers on a rising clk edge where
  // out_valid & out_ready; out_valid depends only on queue state, never on
  // out_ready, and the head stays stable until it is taken.

  localparam logic [ACC_W-1:0] ACC_MAX = '1;

  logic             ct_wash_q, ct_shop_q;
  logic [CNT_W-1:0] seq;
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic             mem_svc [FIFO_DEPTH];
  logic [CNT_W-1:0] mem_id  [FIFO_DEPTH];

  logic             wash_ev, shop_ev, pop, wr0, wr1, dropped;
  logic [1:0]       n_req;
  logic [LVL_W:0]   free_slots;
  logic             rec0_svc;
  logic [ACC_W:0]   add_val;
  logic [ACC_W+1:0] sum;
  logic [ACC_W-1:0] total_next;

  assign wash_ev   = ct_wash & ~ct_wash_q;
  assign shop_ev   = ct_shop & ~ct_shop_q;
  assign n_req     = {1'b0, wash_ev} + {1'b0, shop_ev};
  assign out_valid = (level != '0);
  assign pop       = out_valid & out_ready;
  assign out_svc   = mem_svc[rd_ptr];
  assign out_id    = mem_id[rd_ptr];

  // A pop in the same cycle frees its slot for an incoming record.
  assign free_slots = (LVL_W+1)'(FIFO_DEPTH) - {1'b0, level}
                    + {{LVL_W{1'b0}}, pop};
  assign wr0 = (n_req != 2'd0) && (free_slots != '0);
  assign wr1 = (n_req == 2'd2) && (free_slots >= {{(LVL_W-1){1'b0}}, 2'd2});
  assign dropped = ((n_req != 2'd0) && !wr0) || ((n_req == 2'd2) && !wr1);

  // With a single event the first record belongs to whichever station fired.
  assign rec0_svc = ~wash_ev;

  always_comb begin
    add_val = '0;
    if (wash_ev) add_val = add_val + (ACC_W+1)'(PRICE_WASH);
    if (shop_ev) add_val = add_val + (ACC_W+1)'(PRICE_SHOP);
    sum = {2'b00, (clr_total ? '0 : total)} + {1'b0, add_val};
    total_next = (sum > {2'b00, ACC_MAX}) ? ACC_MAX : sum[ACC_W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ct_wash_q <= 1'b0;
      ct_shop_q <= 1'b0;
      seq       <= '0;
      wash_cnt  <= '0;
      shop_cnt  <= '0;
      total     <= '0;
      drop      <= 1'b0;
      level     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_svc[i] <= 1'b0;
        mem_id[i]  <= '0;
      end
    end else begin
      ct_wash_q <= ct_wash;
      ct_shop_q <= ct_shop;
      seq       <= seq + {{(CNT_W-2){1'b0}}, n_req};
      wash_cnt  <= wash_cnt + {{(CNT_W-1){1'b0}}, wash_ev};
      shop_cnt  <= shop_cnt + {{(CNT_W-1){1'b0}}, shop_ev};
      total     <= total_next;
      if (dropped)        drop <= 1'b1;
      else if (clr_total) drop <= 1'b0;
      if (wr0) begin
        mem_svc[wr_ptr] <= rec0_svc;
        mem_id[wr_ptr]  <= seq;
      end
      if (wr1) begin
        mem_svc[wr_ptr + PTR_W'(1)] <= 1'b1;
        mem_id[wr_ptr + PTR_W'(1)]  <= seq + CNT_W'(1);
      end
      wr_ptr <= wr_ptr + {{(PTR_W-1){1'b0}}, wr0} + {{(PTR_W-1){1'b0}}, wr1};
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      level <= level + {{PTR_W{1'b0}}, wr0} + {{PTR_W{1'b0}}, wr1}
                     - {{PTR_W{1'b0}}, pop};
    end
  end

endmodule

// File: tb/tb_service_ledger.sv
// Scoreboard bench for service_ledger: a behavioural model predicts counters,
// total, drop and the ticket stream; tickets are queued and checked on pop.
module tb_service_ledger;
  localparam int CNT_W = 8;
  localparam int ACC_W = 12;
  localparam int DEPTH = 4;
  localparam int LVL_W = 3;
  localparam int ACC_MAX = 4095;

  logic             clk, reset;
  logic             ct_wash, ct_shop, clr_total, out_ready;
  logic             out_valid, out_svc, drop;
  logic [CNT_W-1:0] out_id, wash_cnt, shop_cnt;
  logic [ACC_W-1:0] total;
  logic [LVL_W-1:0] level;

  service_ledger dut (
    .clk(clk), .reset(reset), .ct_wash(ct_wash), .ct_shop(ct_shop),
    .clr_total(clr_total), .out_ready(out_ready), .out_valid(out_valid),
    .out_svc(out_svc), .out_id(out_id), .wash_cnt(wash_cnt),
    .shop_cnt(shop_cnt), .total(total), .level(level), .drop(drop)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [CNT_W:0] exp_q[$];
  logic m_wq, m_sq, m_drop;
  int   m_seq, m_wash, m_shop, m_total;

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_wq = 0; m_sq = 0; m_drop = 0;
    m_seq = 0; m_wash = 0; m_shop = 0; m_total = 0;
  endtask

  task automatic check_state();
    check_val("level",    32'(level),    32'(exp_q.size()));
    check_val("wash_cnt", 32'(wash_cnt), 32'(m_wash));
    check_val("shop_cnt", 32'(shop_cnt), 32'(m_shop));
    check_val("total",    32'(total),    32'(m_total));
    check_val("drop",     32'(drop),     32'(m_drop));
  endtask

  // driver: one clock cycle with the given inputs, model updated in lockstep
  task automatic cycle(input logic w, input logic s, input logic r, input logic c);
    logic we, se, pop, lost;
    int   free, add;
    ct_wash = w; ct_shop = s; out_ready = r; clr_total = c;
    we = w & ~m_wq; se = s & ~m_sq;
    m_wq = w; m_sq = s;
    check_val("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0)
      check_val("head", 32'({out_svc, out_id}), 32'(exp_q[0]));
    pop = r && (exp_q.size() != 0);
    if (pop) void'(exp_q.pop_front());
    free = DEPTH - exp_q.size();
    lost = 1'b0;
    add  = 0;
    if (we) begin
      if (free > 0) begin
        exp_q.push_back({1'b0, 8'(m_seq)});
        free--;
      end else lost = 1'b1;
      m_seq  = (m_seq + 1) % 256;
      m_wash = (m_wash + 1) % 256;
      add += 5;
    end
    if (se) begin
      if (free > 0) begin
        exp_q.push_back({1'b1, 8'(m_seq)});
        free--;
      end else lost = 1'b1;
      m_seq  = (m_seq + 1) % 256;
      m_shop = (m_shop + 1) % 256;
      add += 9;
    end
    m_total = (c ? 0 : m_total) + add;
    if (m_total > ACC_MAX) m_total = ACC_MAX;
    if (lost) m_drop = 1'b1;
    else if (c) m_drop = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_state();
  endtask

  initial begin
    reset = 1'b1;
    ct_wash = 0; ct_shop = 0; clr_total = 0; out_ready = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check_val("rst_valid", 32'(out_valid), 0);
    check_val("rst_svc",   32'(out_svc),   0);
    check_val("rst_id",    32'(out_id),    0);
    check_state();
    reset = 1'b0;

    // held level counts once
    cycle(1, 0, 0, 0);
    check_val("t1_total", 32'(total), 5);
    check_val("t1_id",    32'(out_id), 0);
    check_val("t1_svc",   32'(out_svc), 0);
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    check_val("t1_wash_cnt", 32'(wash_cnt), 1);
    check_val("t1_level",    32'(level), 1);
    cycle(0, 0, 1, 1);

    // simultaneous wash + shop
    cycle(1, 1, 0, 0);
    check_val("t2_level", 32'(level), 2);
    check_val("t2_total", 32'(total), 14);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 1, 1);

    // overflow with cashier stalled
    for (int i = 0; i < 5; i++) begin
      cycle(1, 0, 0, 0);
      cycle(0, 0, 0, 0);
    end
    check_val("t3_level", 32'(level), 4);
    check_val("t3_drop",  32'(drop), 1);
    check_val("t3_total", 32'(total), 25);
    cycle(0, 0, 0, 1);
    check_val("t3_clr_drop", 32'(drop), 0);

    // full queue, pop and event in one cycle
    cycle(0, 1, 1, 0);
    check_val("t4_level", 32'(level), 4);
    check_val("t4_drop",  32'(drop), 0);
    cycle(0, 0, 0, 0);
    repeat (5) cycle(0, 0, 1, 0);

    // saturation
    for (int i = 0; i < 456; i++) begin
      cycle(0, 1, 1, 0);
      cycle(0, 0, 1, 0);
    end
    check_val("t5_sat", 32'(total), ACC_MAX);
    cycle(0, 1, 1, 0);
    check_val("t5_hold", 32'(total), ACC_MAX);
    cycle(1, 0, 1, 1);
    check_val("t5_clr_add", 32'(total), 5);
    cycle(0, 0, 1, 0);

    // random traffic
    for (int i = 0; i < 300; i++)
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));

    // asynchronous reset mid-operation
    repeat (5) cycle(0, 0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      cycle(1, 0, 0, 0);
      cycle(0, 0, 0, 0);
    end
    cycle(0, 0, 1, 0);
    check_val("t6_pre_level", 32'(level), 3);
    check_val("t6_pre_drop",  32'(drop), 1);
    ct_shop = 1'b1;
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_val("t6_valid", 32'(out_valid), 0);
    check_state();
    @(negedge clk);
    reset = 1'b0;
    cycle(0, 1, 0, 0);
    check_val("t6_shop_cnt", 32'(shop_cnt), 1);
    check_val("t6_id",       32'(out_id), 0);
    check_val("t6_svc",      32'(out_svc), 1);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/service_ledger.md
# service_ledger

Downstream stage of the car-wash / workshop service controller. Consumes the two "service complete" levels, counts completed services per station, accumulates revenue with saturation, and queues one ticket record per completion for the cashier through a valid/ready handshake. Sits between the service FSM pair and the cashier display/console logic.

## Interface
- CNT_W, 8, width of per-station counters and ticket sequence number
- ACC_W, 12, width of revenue accumulator
- PRICE_WASH, 5, revenue units added per car-wash completion
- PRICE_SHOP, 9, revenue units added per workshop completion
- FIFO_DEPTH, 4, ticket queue entries (power of 2, ≥2)

- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- ct_wash  in  1  car-wash complete level (high while wash FSM is in its completion state)
- ct_shop  in  1  workshop complete level
- clr_total  in  1  synchronous clear of revenue total and drop flag
- out_ready  in  1  cashier accepts head record
- out_valid  out  1  queue non-empty
- out_svc  out  1  head record station: 0 = wash, 1 = shop
- out_id  out  CNT_W  head record ticket sequence number
- wash_cnt  out  CNT_W  completed washes, wraps modulo 2^CNT_W
- shop_cnt  out  CNT_W  completed workshop jobs, wraps modulo 2^CNT_W
- total  out  ACC_W  revenue, saturates at 2^ACC_W−1
- level  out  log2(FIFO_DEPTH)+1  queue occupancy
- drop  out  1  sticky: a record was lost because the queue was full

## Operation
- Edge detect: registers ct_wash_q/ct_shop_q (reset 0). Event = ct & ~ct_q. Level held high N cycles = one event; a new event requires a low cycle first.
- Wash event: wash_cnt +1; total += PRICE_WASH; enqueue {svc=0, id=seq}; seq +1.
- Shop event: shop_cnt +1; total += PRICE_SHOP; enqueue {svc=1, id=seq}; seq +1.
- Simultaneous events: both processed same cycle; wash gets id=seq, shop gets id=seq+1; seq +2; total += both prices (single saturating add of the sum).
- seq (internal, CNT_W) wraps modulo 2^CNT_W; seq advances even when a record is dropped.
- Queue: show-ahead FIFO, up to 2 writes and 1 read per cycle. Pop when out_valid & out_ready. Free space = FIFO_DEPTH − level + pop (pop frees a slot in the same cycle).
- Insufficient space: write in order wash then shop until space exhausted; remaining record(s) discarded; drop ← 1. Counters and total update regardless of queue space.
- Pop on empty ignored; out_svc/out_id don't-care when out_valid=0.
- clr_total: total ← sum of prices of events in that same cycle (clear then add); drop ← 0 unless a drop occurs that same cycle (drop wins). Counters, seq, queue unaffected.
- Saturation: if total + add > 2^ACC_W−1, total ← 2^ACC_W−1; stays there until clr_total/reset.

## Timing
- Reset values: out_valid 0, out_svc 0, out_id 0, wash_cnt 0, shop_cnt 0, total 0, level 0, drop 0; seq 0; edge registers 0; queue empty.
- Reset asserted mid-operation: everything returns to reset values immediately; a ct level still high after release counts as an event at the first edge (ct_q=0).
- Latency: ct rise sampled at edge N → counters, total, level, out_valid/head updated after edge N (1 cycle). No combinational path input → output.
- Handshake: out_valid never depends on out_ready; head holds stable while out_valid & ~out_ready.
- Full queue + pop + one event same cycle: record accepted, level unchanged, drop stays 0.

## Test plan
- Reset, then ct_wash high 3 cycles -> exactly one event: wash_cnt=1, total=5, level=1, out_valid=1, out_svc=0, out_id=0.
- ct_wash and ct_shop rise same cycle, out_ready=0 -> level=2; pops give (svc0,id0) then (svc1,id1); total=14; seq next=2.
- out_ready=0, 5 separate wash events with FIFO_DEPTH=4 -> level=4, drop=1, wash_cnt=5, total=25; drain gives ids 0..3; clr_total -> total=0, drop=0.
- Queue full, out_ready=1 and shop event same cycle -> level stays 4, drop=0, new tail id correct.
- ACC_W=12: drive 456 shop events -> total saturates at 4095 and holds; clr_total with simultaneous wash event -> total=5.
- Assert reset with level=3, drop=1, counters non-zero -> all outputs 0 asynchronously; ct_shop held high across release -> shop_cnt=1, out_id=0 after first edge.
